lifo_stack: RTL

- Parametrised LIFO stack, the successor to the fixed 8-bit/256-entry stack used by the CPU datapath for call/return and operand spill.
- Adds configurable width and depth, explicit full/empty flags, occupancy count and overflow/underflow error pulses.
- Adds a single-cycle replace-top operation and a registered top-of-stack output that is always valid, instead of a tri-stated pop port.
- Storage is an internal register-file array; no external RAM instance.

---
 rtl/lifo_stack_if.sv | 46 ++++
 rtl/lifo_stack.sv | 114 +++++++++++
 2 files changed

// File: rtl/lifo_stack_if.sv
// rtl/lifo_stack_if.sv - push/pop/data/status bundle for lifo_stack
//
// Ports (master = stack user, slave = lifo_stack):
//   push, pop, din                       user -> stack requests and write data
//   dout, empty, full, count             stack -> user top-of-stack and occupancy
//   overflow, underflow                  stack -> user one-cycle rejection pulses
//   hwm_clr / hwm                        high-water-mark clear and value
//                                        (present only with LIFO_STACK_HWM_EN)
interface lifo_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef LIFO_STACK_HWM_EN
  logic             hwm_clr;
  logic [CW-1:0]    hwm;
`endif

  modport master (
    output push, pop, din,
`ifdef LIFO_STACK_HWM_EN
    output hwm_clr,
    input  hwm,
`endif
    input  dout, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, din,
`ifdef LIFO_STACK_HWM_EN
    input  hwm_clr,
    output hwm,
`endif
    output dout, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised register-file LIFO stack with replace-top
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   lifo_stack_if.slave: push/pop/din in; dout (registered top, 0 when
//         empty), empty, full, count, overflow/underflow pulses out
// Optional: define LIFO_STACK_HWM_EN to add the high-water mark (bus.hwm,
//           bus.hwm_clr).
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  lifo_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);
  localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             is_empty;
  logic             is_full;
  logic             do_write;
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CDEPTH);

  // Replace-top overwrites the current top slot; a plain push (or push+pop
  // on an empty stack, where count is 0) writes the next free slot.
  assign wr_ptr   = (bus.pop && !is_empty) ? count_q - ONE : count_q;
  // Entry below the current top, which becomes the new top after a pop.
  assign rd_ptr   = count_q - TWO;
  assign do_write = bus.push && (bus.pop || !is_full);

  // Storage carries no reset; contents past count are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[wr_ptr[AW-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      case ({bus.push, bus.pop})
        2'b10: begin
          if (is_full) begin
            overflow_q <= 1'b1;
          end else begin
            count_q <= count_q + ONE;
            dout_q  <= bus.din;
          end
        end
        2'b01: begin
          if (is_empty) begin
            underflow_q <= 1'b1;
          end else begin
            count_q <= count_q - ONE;
            dout_q  <= (count_q >= TWO) ? mem[rd_ptr[AW-1:0]] : '0;
          end
        end
        2'b11: begin
          // On empty this degenerates to a push; otherwise count holds.
          if (is_empty) begin
            count_q <= ONE;
          end
          dout_q <= bus.din;
        end
        default: ;
      endcase
    end
  end

`ifdef LIFO_STACK_HWM_EN
  logic [CW-1:0] hwm_q;

  // Tracks the registered count, so a new maximum appears one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (bus.hwm_clr) begin
      hwm_q <= count_q;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end

  assign bus.hwm = hwm_q;
`endif

  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule
